// File: rtl/key_fifo.sv
// Keyboard character buffer: edge-detects key events, filters NUL codes and
// queues ASCII bytes in a first-word-fall-through FIFO with a sticky overflow flag.
module key_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_NUL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     ascii_in,
    input  logic                  scan_code_ready,
    input  logic                  rd_en,
    input  logic                  clr_ovf,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  wr_pulse
);

    localparam int                   DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic                  prev_ready_q;

    logic key_event, wr_req, pop, wr_acc, ovf_set;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign wr_pulse = wr_pulse_q;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        key_event  = scan_code_ready && !prev_ready_q;
        wr_req     = key_event && !((DROP_NUL != 0) && (ascii_in == '0));
        pop        = rd_en && !empty;
        // A full FIFO still takes a write when the same cycle frees a slot.
        wr_acc     = wr_req && (!full || pop);
        ovf_set    = wr_req && full && !pop;

        wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_pulse_d = wr_acc;

        count_d = count_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            wr_pulse_q   <= 1'b0;
            prev_ready_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            wr_pulse_q   <= wr_pulse_d;
            prev_ready_q <= scan_code_ready;
        end
    end

    // Storage is deliberately not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= ascii_in;
        end
    end

endmodule

// File: tb/tb_key_fifo.sv
// Bench for key_fifo: two instances (NUL filtering on and off) driven in lockstep,
// queue-based reference model and a negedge read-data scoreboard monitor.
module tb_key_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ascii_in;
    logic       scan_code_ready;
    logic       rd_en;
    logic       clr_ovf;

    logic [7:0] rd_data_w  [2];
    logic       empty_w    [2];
    logic       full_w     [2];
    logic [4:0] count_w    [2];
    logic       overflow_w [2];
    logic       wr_pulse_w [2];

    int errors = 0;
    int checks = 0;

    logic [7:0] mq [2][$];
    logic [7:0] sb [2][$];
    bit         prev_m  [2];
    bit         ovf_m   [2];
    bit         pulse_m [2];

    always #5 clk = ~clk;

    key_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .DROP_NUL(1)) u_drop (
        .clk(clk), .reset(reset), .ascii_in(ascii_in), .scan_code_ready(scan_code_ready),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data_w[0]), .empty(empty_w[0]),
        .full(full_w[0]), .count(count_w[0]), .overflow(overflow_w[0]), .wr_pulse(wr_pulse_w[0])
    );

    key_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .DROP_NUL(0)) u_keep (
        .clk(clk), .reset(reset), .ascii_in(ascii_in), .scan_code_ready(scan_code_ready),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data_w[1]), .empty(empty_w[1]),
        .full(full_w[1]), .count(count_w[1]), .overflow(overflow_w[1]), .wr_pulse(wr_pulse_w[1])
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[dut%0d] t=%0t actual=0x%0h expected=0x%0h", name, k, $time, act, exp);
        end
    endtask

    // Reference: a FIFO is just a byte queue capped at 16 entries.
    task automatic model_step(input int k, input bit rdy, input logic [7:0] a,
                              input bit rd, input bit clr, input bit rst);
        int  sz;
        bit  ev, wreq, popm, acc;
        if (rst) begin
            mq[k].delete();
            sb[k].delete();
            prev_m[k]  = 1'b1;
            ovf_m[k]   = 1'b0;
            pulse_m[k] = 1'b0;
            return;
        end
        sz   = mq[k].size();
        ev   = rdy && !prev_m[k];
        prev_m[k] = rdy;
        wreq = ev && !(k == 0 && a == 8'h00);
        popm = rd && sz > 0;
        acc  = wreq && (sz < 16 || popm);
        if (popm) void'(mq[k].pop_front());
        if (acc) begin
            mq[k].push_back(a);
            sb[k].push_back(a);
        end
        if (wreq && sz == 16 && !popm) ovf_m[k] = 1'b1;
        else if (clr) ovf_m[k] = 1'b0;
        pulse_m[k] = acc;
    endtask

    task automatic step(input bit rdy, input logic [7:0] a, input bit rd,
                        input bit clr, input bit rst);
        scan_code_ready = rdy;
        ascii_in        = a;
        rd_en           = rd;
        clr_ovf         = clr;
        reset           = rst;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, rdy, a, rd, clr, rst);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("count",    k, int'(count_w[k]),    mq[k].size());
            chk("empty",    k, int'(empty_w[k]),    int'(mq[k].size() == 0));
            chk("full",     k, int'(full_w[k]),     int'(mq[k].size() == 16));
            chk("overflow", k, int'(overflow_w[k]), int'(ovf_m[k]));
            chk("wr_pulse", k, int'(wr_pulse_w[k]), int'(pulse_m[k]));
            if (mq[k].size() == 0) chk("rd_data_empty", k, int'(rd_data_w[k]), 0);
        end
    endtask

    task automatic send(input logic [7:0] a, input int hold, input bit rd);
        step(1'b1, a, rd, 1'b0, 1'b0);
        for (int i = 1; i < hold; i++) step(1'b1, a, 1'b0, 1'b0, 1'b0);
        step(1'b0, a, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Consumer side: every handshaked pop must deliver the oldest accepted byte.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset === 1'b0 && rd_en === 1'b1 && empty_w[k] === 1'b0) begin
                if (sb[k].size() == 0) chk("pop_unexpected", k, int'(rd_data_w[k]), -1);
                else chk("rd_data", k, int'(rd_data_w[k]), int'(sb[k].pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        send(8'h41, 2, 1'b0);
        chk("first_byte", 0, int'(rd_data_w[0]), 8'h41);
        pop_n(1);

        send(8'h48, 5, 1'b0);
        send(8'h49, 5, 1'b0);
        pop_n(3);

        for (int b = 8'h30; b <= 8'h40; b++) send(8'(b), 1, 1'b0);
        pop_n(17);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int b = 0; b < 16; b++) send(8'(8'h60 + b), 1, 1'b0);
        send(8'h7A, 1, 1'b1);
        pop_n(17);
        send(8'h55, 1, 1'b1);
        pop_n(1);

        send(8'h00, 2, 1'b0);
        pop_n(2);

        for (int b = 0; b < 20; b++) send(8'(8'hA0 + b), 1, (b % 3) == 2);
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("reset_count", 0, int'(count_w[0]), 0);

        for (int i = 0; i < 1500; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            step($urandom_range(0, 2) != 0, a, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end
        pop_n(18);
        for (int k = 0; k < 2; k++) chk("sb_drained", k, sb[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
